// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-port byte-enable RAM slice.
package ram_pkg;

  typedef enum logic {
    RamIdle,
    RamClear
  } ram_clr_state_e;

  localparam int unsigned MaxNb   = 128;
  localparam int unsigned MaxNbW  = $clog2(MaxNb);
  localparam int unsigned MaxW    = 1024;
  localparam int unsigned MaxWW   = $clog2(MaxW);

  // Expands per-lane enables into a bit mask; callers truncate to their width.
  function automatic logic [MaxW-1:0] be_to_mask(input logic [MaxNb-1:0] be,
                                                 input int unsigned      nb,
                                                 input int unsigned      bytew);
    logic [MaxW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if ((i / bytew) < nb) m[MaxWW'(i)] = be[MaxNbW'(i / bytew)];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Memory-clear sequencer: sweeps every word once after reset or on request.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned Depth        = 256,
  parameter int unsigned Aw           = 8,
  parameter bit          ClearOnReset = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  output logic          clr_we,
  output logic [Aw-1:0] clr_addr,
  output logic          ready
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  ram_clr_state_e state_q, state_d;
  logic [Aw-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ClearOnReset ? RamClear : RamIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      RamIdle: begin
        ready = 1'b1;
        if (clear_i) state_d = RamClear;
      end
      RamClear: begin
        clr_we = 1'b1;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = RamIdle;
        end else begin
          cnt_d = cnt_q + Aw'(1);
        end
      end
      default: state_d = RamIdle;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_two_sync_be.sv
// Synchronous two-port RAM with byte enables, optional output register,
// read-during-write forwarding and a hardware clear sweep.
module ram_two_sync_be
  import ram_pkg::*;
#(
  parameter int unsigned       Width        = 32,
  parameter int unsigned       Depth        = 256,
  parameter int unsigned       ByteW        = 8,
  parameter bit                OutReg       = 1'b0,
  parameter bit                Forward      = 1'b1,
  parameter bit                ClearOnReset = 1'b1,
  parameter logic [Width-1:0]  ClearValue   = '0,
  localparam int unsigned      Nb           = Width / ByteW,
  localparam int unsigned      Aw           = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Nb-1:0]    wbe_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             clear_i,
  output logic             ready_o
);

  logic [Width-1:0] mem [Depth];

  logic          clr_we, ready;
  logic [Aw-1:0] clr_addr;

  ram_clear_seq #(
    .Depth       (Depth),
    .Aw          (Aw),
    .ClearOnReset(ClearOnReset)
  ) u_clear_seq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .ready   (ready)
  );

  assign ready_o = ready;

  logic             wr_in_range, rd_in_range, usr_we, rd_acc, fwd_hit;
  logic [Width-1:0] be_mask, rd_mem, rd_word;

  assign wr_in_range = 32'(waddr_i) < Depth;
  assign rd_in_range = 32'(raddr_i) < Depth;
  assign usr_we      = we_i & ready & wr_in_range;
  assign rd_acc      = re_i & ready;
  assign be_mask     = Width'(be_to_mask(MaxNb'(wbe_i), Nb, ByteW));

  // The sweep owns the write port while it runs; user writes are gated by ready.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= ClearValue;
    end else if (usr_we) begin
      for (int unsigned k = 0; k < Nb; k++) begin
        if (wbe_i[k]) mem[waddr_i][k*ByteW +: ByteW] <= wdata_i[k*ByteW +: ByteW];
      end
    end
  end

  assign rd_mem  = rd_in_range ? mem[raddr_i] : '0;
  assign fwd_hit = Forward && usr_we && (waddr_i == raddr_i);
  assign rd_word = fwd_hit ? ((rd_mem & ~be_mask) | (wdata_i & be_mask)) : rd_mem;

  logic             v1_q;
  logic [Width-1:0] d1_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) d1_q <= rd_word;
    end
  end

  if (OutReg) begin : g_outreg
    logic             v2_q;
    logic [Width-1:0] d2_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign rvalid_o = v2_q;
    assign rdata_o  = d2_q;
  end else begin : g_noreg
    assign rvalid_o = v1_q;
    assign rdata_o  = d1_q;
  end

endmodule

// File: doc/ram_two_sync_be.md
Name: ram_two_sync_be

Overview:
Next-generation synchronous two-port RAM with the following additions:
- per-byte write enables
- selectable read latency (1 or 2 cycles)
- configurable read-during-write forwarding
- hardware memory-clear sequencer, run after reset or on request

One shared clock. One write port and one read port, usable in the same cycle. Intended as the storage element under FIFOs and buffers that need deterministic initial contents and partial-word updates.

Parameters:
- Width, 32: data word width in bits. Must be a multiple of ByteW.
- Depth, 256: number of words. Need not be a power of two.
- ByteW, 8: bits per byte lane. Nb = Width/ByteW lanes.
- OutReg, 0: 0 gives read latency 1. 1 adds an output register, giving read latency 2.
- Forward, 1: 1 means a same-address read-during-write returns the post-write word. 0 means it returns the pre-write word.
- ClearOnReset, 1: 1 runs the clear sweep after every reset.
- ClearValue, 0: Width-bit value written to every word by the clear sweep.
- Aw (localparam): max(1, $clog2(Depth)).

Ports:
- clk_i  in  1  clock. Only clock; all logic on the rising edge.
- rst_ni  in  1  reset. Synchronous, active-low.
- we_i  in  1  write request.
- waddr_i  in  Aw  write address.
- wdata_i  in  Width  write data.
- wbe_i  in  Nb  byte enables. Bit k enables lane k, i.e. bits [k*ByteW +: ByteW].
- re_i  in  1  read request.
- raddr_i  in  Aw  read address.
- rdata_o  out  Width  read data.
- rvalid_o  out  1  one-cycle pulse: rdata_o is valid for one accepted read.
- clear_i  in  1  starts a clear sweep. Sampled only in IDLE.
- ready_o  out  1  high when requests are accepted. Low during a clear sweep.

Behaviour:
- Reset (rst_ni low at a rising edge):
  - rdata_o=0, rvalid_o=0, all read-pipeline valids cleared, clear counter=0.
  - state=CLEAR if ClearOnReset=1, else IDLE.
  - ready_o=0 while in CLEAR.
  - Memory contents are not reset directly; only the sweep initialises them.
- State machine, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_i=1.
  - In CLEAR: write ClearValue to address clr_cnt, all lanes, then increment clr_cnt. One word per cycle.
  - CLEAR -> IDLE on the cycle the write to Depth-1 occurs. ready_o goes high the following cycle, so a sweep takes exactly Depth cycles of ready_o=0.
  - clear_i while in CLEAR is ignored.
  - Reset during CLEAR restarts the sweep from address 0.
- Request gating:
  - we_i and re_i with ready_o=0 are dropped: no memory update, no rvalid_o.
  - No backpressure beyond ready_o. Callers must check ready_o.
- Write (we_i=1 and ready_o=1):
  - Lanes with wbe_i[k]=1 take wdata_i. Other lanes keep their old value.
  - we_i=1 with wbe_i=0 is a no-op.
- Read (re_i=1 and ready_o=1):
  - OutReg=0: rdata_o and rvalid_o update on edge N+1.
  - OutReg=1: they update on edge N+2.
  - Fully pipelined: one read per cycle, and rvalid_o stays high for back-to-back reads.
  - rdata_o holds its last value when rvalid_o=0.
- Simultaneous read and write:
  - Different addresses: independent.
  - Same address, Forward=1: read returns the byte-merged new word, i.e. enabled lanes from wdata_i and the rest from memory.
  - Same address, Forward=0: read returns the old word.
- Out-of-range addresses (address >= Depth, only possible when Depth is not a power of two):
  - Write is dropped.
  - Read returns 0 with a normal rvalid_o pulse.
- Reset during in-flight reads: pending reads are discarded and produce no rvalid_o.

Decomposition:
- Package ram_pkg:
  - clear-FSM enum ram_clr_state_e {RamIdle, RamClear}
  - function be_to_mask(Nb, ByteW), which expands byte enables to a bit mask
- Sub-module ram_clear_seq:
  - contains the FSM and address counter
  - outputs clr_we, clr_addr and ready
  - the top muxes these onto the write port
- Storage array and read pipeline stay in the top module.

Test Plan:
All tests use Width=32, Depth=16, ByteW=8 unless stated.
1. Reset, then release, with ClearOnReset=1 -> ready_o=0 for exactly 16 cycles, then 1. Read addr 5 (OutReg=0) -> rdata_o=0x00000000, with rvalid_o high 1 cycle after re_i.
2. Byte enables: write 0x11223344 to addr 3 with be=1111, then 0xAABBCCDD to addr 3 with be=0101, then read addr 3 -> 0x11BB33DD.
3. Read-during-write: addr 7 holds 0. Same cycle, write 0xDEADBEEF (be=1111) and read addr 7 -> 0xDEADBEEF with Forward=1, 0x00000000 with Forward=0. With Forward=1 and be=0011 -> 0x0000BEEF.
4. OutReg=1: read addrs 0..3 on consecutive cycles (contents 0xA0..0xA3) -> rvalid_o high for 4 consecutive cycles starting at edge +2, data 0xA0,0xA1,0xA2,0xA3 in order.
5. After filling memory, pulse clear_i -> ready_o=0 for 16 cycles. A write to addr 2 during the sweep is ignored. Afterwards all addresses read 0. Then assert reset at sweep cycle 8 -> the sweep restarts and ready_o stays low for a full 16 cycles after release.
6. Depth=12: write 0x55 to addr 13 -> no change to any word. Read addr 13 -> rdata_o=0, rvalid_o=1.
